// File: rtl/fft_sample_loader.sv
// Streams samples into the 32-entry FFT register memory, zero-pads short frames and
// hands the frame to the accelerator. Define FFT_LOADER_BITREV_EN for bit-reversed addressing.
module fft_sample_loader #(
    parameter int MEMWIDTH  = 32,
    parameter int WORDWIDTH = 16,
    localparam int AW       = $clog2(MEMWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [WORDWIDTH-1:0] s_data_i,
    input  logic                 s_last_i,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [WORDWIDTH-1:0] mem_data_o,
    output logic                 frame_valid_o,
    input  logic                 frame_start_i,
    input  logic                 accel_done_i,
    output logic [AW:0]          fill_level_o,
    output logic [7:0]           frame_cnt_o
);

    typedef enum logic [1:0] {FILL, PAD, HANDOFF, BUSY} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        idx;
    logic                 wr;
    logic                 at_last;
    logic                 mem_en_q;
    logic [AW-1:0]        mem_addr_q;
    logic [WORDWIDTH-1:0] mem_data_q;
    logic                 frame_valid_q;
    logic [AW:0]          fill_q;
    logic [7:0]           frame_cnt_q;

    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] i);
        logic [AW-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
        for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
`else
        r = i;
`endif
        return r;
    endfunction

    assign s_ready_o = (state == FILL);
    assign at_last   = (idx == AW'(MEMWIDTH - 1));

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        case (state)
            FILL: if (s_valid_i) begin
                wr = 1'b1;
                if (at_last)       state_nxt = HANDOFF;
                else if (s_last_i) state_nxt = PAD;
            end
            PAD: begin
                wr = 1'b1;
                if (at_last) state_nxt = HANDOFF;
            end
            HANDOFF: if (frame_start_i) state_nxt = BUSY;
            BUSY:    if (accel_done_i)  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        // Abort wins over everything, including a sample offered this cycle.
        if (clear_i) begin
            state_nxt = FILL;
            wr        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx           <= '0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            frame_valid_q <= 1'b0;
            fill_q        <= '0;
            frame_cnt_q   <= '0;
        end else if (clear_i) begin
            idx           <= '0;
            mem_en_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            fill_q        <= '0;
        end else begin
            mem_en_q      <= wr;
            // Rises one cycle after entering HANDOFF, i.e. after the final strobe is visible.
            frame_valid_q <= (state == HANDOFF) && !frame_start_i;
            if (wr) begin
                mem_addr_q <= map_addr(idx);
                mem_data_q <= (state == PAD) ? '0 : s_data_i;
                idx        <= idx + AW'(1);
                fill_q     <= fill_q + (AW+1)'(1);
            end
            if (state == HANDOFF && frame_start_i) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (state == BUSY && accel_done_i) begin
                idx    <= '0;
                fill_q <= '0;
            end
        end
    end

    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_en_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign frame_valid_o = frame_valid_q;
    assign fill_level_o  = fill_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Randomized bench for fft_sample_loader: strobes are logged by a monitor and compared
// against the expected frame image (data, zero padding, address order).
module tb_fft_sample_loader;
    localparam int MW = 32;
    localparam int WW = 16;
    localparam int AW = 5;

    logic          clk = 0, rst = 0, clear_i = 0, s_valid_i = 0, s_last_i = 0;
    logic          frame_start_i = 0, accel_done_i = 0;
    logic [WW-1:0] s_data_i = '0;
    logic          s_ready_o, mem_en_o, mem_we_o, frame_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic [WW-1:0] mem_data_o;
    logic [AW:0]   fill_level_o;
    logic [7:0]    frame_cnt_o;

    fft_sample_loader #(.MEMWIDTH(MW), .WORDWIDTH(WW)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .frame_valid_o(frame_valid_o), .frame_start_i(frame_start_i), .accel_done_i(accel_done_i),
        .fill_level_o(fill_level_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    typedef struct { int addr; int data; int c; } wr_t;
    wr_t wq[$];
    int   fv_rise = -1;
    logic fv_prev = 1'b0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_en_o === 1'b1) begin
            wq.push_back('{int'(mem_addr_o), int'(mem_data_o), cyc});
            tests++;
            if (mem_we_o !== 1'b1) begin
                fails++; $display("FAIL we_eq_en: we=%b required 1", mem_we_o);
            end
        end
        if (frame_valid_o === 1'b1 && !fv_prev) fv_rise = cyc;
        fv_prev = (frame_valid_o === 1'b1);
    end

    // Expected address of frame index i: natural order, or bit-reversed order.
    function automatic int amap(input int i);
`ifdef FFT_LOADER_BITREV_EN
        int r = 0, v = i;
        for (int b = 0; b < AW; b++) begin r = r * 2 + v % 2; v = v / 2; end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic test_reset();
        @(negedge clk);
        tests++; if (s_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", s_ready_o); end
        tests++; if (mem_en_o !== 1'b0) begin fails++; $display("FAIL rst_en: got %b want 0", mem_en_o); end
        tests++; if (frame_valid_o !== 1'b0) begin fails++; $display("FAIL rst_fv: got %b want 0", frame_valid_o); end
        tests++; if (fill_level_o !== 0) begin fails++; $display("FAIL rst_fill: got %0d want 0", fill_level_o); end
        tests++; if (frame_cnt_o !== 0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt_o); end
        tests++; if (mem_addr_o !== 0 || mem_data_o !== 0) begin fails++; $display("FAIL rst_addr_data: got %0d/%0h want 0/0", mem_addr_o, mem_data_o); end
    endtask

    task automatic test_full_frame();
        int d[MW];
        int n;
        wq.delete(); fv_rise = -1;
        for (int i = 0; i < MW; i++) begin
            d[i] = (i < 2) ? i + 1 : int'($urandom_range(0, 16'hFFFF));
            @(negedge clk); s_valid_i = 1; s_data_i = WW'(d[i]); s_last_i = 0;
        end
        @(negedge clk); s_valid_i = 0;
        tests++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready_low: got %b want 0", s_ready_o); end
        repeat (3) @(negedge clk);
        n = wq.size();
        tests++; if (n != MW) begin fails++; $display("FAIL full_count: got %0d want %0d", n, MW); end
        for (int i = 0; i < MW && i < n; i++) begin
            tests++;
            if (wq[i].addr != amap(i) || wq[i].data != d[i] || wq[i].c != wq[0].c + i) begin
                fails++; $display("FAIL full_wr[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d",
                                  i, wq[i].addr, wq[i].data, wq[i].c, amap(i), d[i], wq[0].c + i);
            end
        end
        tests++; if (fill_level_o !== MW) begin fails++; $display("FAIL full_fill: got %0d want %0d", fill_level_o, MW); end
        tests++; if (frame_valid_o !== 1'b1) begin fails++; $display("FAIL full_fv: got %b want 1", frame_valid_o); end
        if (n > 0) begin
            tests++; if (fv_rise != wq[n-1].c + 1) begin fails++; $display("FAIL full_fv_timing: got %0d want %0d", fv_rise, wq[n-1].c + 1); end
        end
    endtask

    task automatic test_handoff_busy();
        logic [WW-1:0] v;
        @(negedge clk); frame_start_i = 1;
        @(negedge clk); frame_start_i = 0;
        exp_cnt = (exp_cnt + 1) % 256;
        tests++; if (frame_valid_o !== 1'b0) begin fails++; $display("FAIL busy_fv: got %b want 0", frame_valid_o); end
        tests++; if (frame_cnt_o !== 8'(exp_cnt)) begin fails++; $display("FAIL busy_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        wq.delete();
        s_valid_i = 1; s_data_i = WW'($urandom);
        repeat (5) @(negedge clk);
        frame_start_i = 1;
        tests++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b want 0", s_ready_o); end
        @(negedge clk); frame_start_i = 0; accel_done_i = 1;
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL busy_nostrobe: got %0d want 0", wq.size()); end
        tests++; if (frame_cnt_o !== 8'(exp_cnt)) begin fails++; $display("FAIL busy_start_ignored: got %0d want %0d", frame_cnt_o, exp_cnt); end
        v = WW'($urandom);
        @(negedge clk); accel_done_i = 0; s_data_i = v;
        tests++; if (s_ready_o !== 1'b1) begin fails++; $display("FAIL done_ready: got %b want 1", s_ready_o); end
        tests++; if (fill_level_o !== 0) begin fails++; $display("FAIL done_fill: got %0d want 0", fill_level_o); end
        @(negedge clk); s_valid_i = 0;
        @(negedge clk);
        tests++;
        if (wq.size() != 1 || wq[0].addr != amap(0) || wq[0].data != int'(v)) begin
            fails++; $display("FAIL done_next_addr: got n=%0d a=%0d d=%0h want n=1 a=%0d d=%0h", wq.size(),
                              (wq.size() > 0) ? wq[0].addr : -1, (wq.size() > 0) ? wq[0].data : -1, amap(0), v);
        end
        @(negedge clk); frame_start_i = 1;
        @(negedge clk); frame_start_i = 0; clear_i = 1;
        @(negedge clk); clear_i = 0;
        tests++; if (frame_cnt_o !== 8'(exp_cnt)) begin fails++; $display("FAIL fill_start_ignored: got %0d want %0d", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_short_frame();
        int d[MW];
        int k, n, t;
        for (int it = 0; it < 3; it++) begin
            k = (it == 0) ? 4 : int'($urandom_range(0, MW - 2));
            wq.delete(); fv_rise = -1;
            for (int i = 0; i <= k; i++) begin
                d[i] = (it == 0 && i == k) ? 16'h00A5 : int'($urandom_range(0, 16'hFFFF));
                @(negedge clk); s_valid_i = 1; s_data_i = WW'(d[i]); s_last_i = (i == k);
            end
            @(negedge clk); s_valid_i = 0; s_last_i = 0;
            t = 0;
            while (frame_valid_o !== 1'b1 && t < 60) begin @(negedge clk); t++; end
            tests++; if (t >= 60) begin fails++; $display("FAIL pad_timeout: k=%0d fv=%b want 1", k, frame_valid_o); end
            @(negedge clk);
            n = wq.size();
            tests++; if (n != MW) begin fails++; $display("FAIL pad_count: k=%0d got %0d want %0d", k, n, MW); end
            for (int i = 0; i < MW && i < n; i++) begin
                tests++;
                if (wq[i].addr != amap(i) || wq[i].data != ((i <= k) ? d[i] : 0) || wq[i].c != wq[0].c + i) begin
                    fails++; $display("FAIL pad_wr[%0d]: k=%0d got a=%0d d=%0h want a=%0d d=%0h", i, k,
                                      wq[i].addr, wq[i].data, amap(i), (i <= k) ? d[i] : 0);
                end
            end
            tests++; if (fill_level_o !== MW) begin fails++; $display("FAIL pad_fill: got %0d want %0d", fill_level_o, MW); end
            if (n > 0) begin
                tests++; if (fv_rise != wq[n-1].c + 1) begin fails++; $display("FAIL pad_fv_timing: got %0d want %0d", fv_rise, wq[n-1].c + 1); end
            end
            @(negedge clk); frame_start_i = 1;
            @(negedge clk); frame_start_i = 0; accel_done_i = 1;
            @(negedge clk); accel_done_i = 0;
            exp_cnt = (exp_cnt + 1) % 256;
            tests++; if (frame_cnt_o !== 8'(exp_cnt)) begin fails++; $display("FAIL pad_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        end
    endtask

    task automatic test_toggle_and_clear();
        int d[$];
        logic [WW-1:0] v;
        wq.delete();
        for (int i = 0; i < 8; i++) begin
            v = WW'($urandom);
            @(negedge clk); s_valid_i = (i % 2 == 0); s_data_i = v;
            if (i % 2 == 0) d.push_back(int'(v));
        end
        @(negedge clk); s_valid_i = 0;
        @(negedge clk);
        tests++; if (wq.size() != 4) begin fails++; $display("FAIL toggle_count: got %0d want 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            tests++;
            if (wq[i].addr != amap(i) || wq[i].data != d[i]) begin
                fails++; $display("FAIL toggle_wr[%0d]: got a=%0d d=%0h want a=%0d d=%0h", i, wq[i].addr, wq[i].data, amap(i), d[i]);
            end
        end
        tests++; if (fill_level_o !== 4) begin fails++; $display("FAIL toggle_fill: got %0d want 4", fill_level_o); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); s_valid_i = 1; s_data_i = WW'($urandom);
        end
        @(negedge clk); s_valid_i = 0;
        @(negedge clk);
        tests++; if (fill_level_o !== 10) begin fails++; $display("FAIL clear_pre_fill: got %0d want 10", fill_level_o); end
        wq.delete();
        @(negedge clk); clear_i = 1; s_valid_i = 1; s_data_i = WW'($urandom);
        tests++; if (s_ready_o !== 1'b1) begin fails++; $display("FAIL clear_ready: got %b want 1", s_ready_o); end
        v = WW'($urandom);
        @(negedge clk); clear_i = 0; s_data_i = v;
        tests++; if (fill_level_o !== 0) begin fails++; $display("FAIL clear_fill: got %0d want 0", fill_level_o); end
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL clear_nostrobe: got %0d want 0", wq.size()); end
        @(negedge clk); s_valid_i = 0;
        @(negedge clk);
        tests++;
        if (wq.size() != 1 || wq[0].addr != amap(0) || wq[0].data != int'(v)) begin
            fails++; $display("FAIL clear_next_addr: got n=%0d want n=1 a=%0d d=%0h", wq.size(), amap(0), v);
        end
        tests++; if (frame_cnt_o !== 8'(exp_cnt)) begin fails++; $display("FAIL clear_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        @(negedge clk); clear_i = 1;
        @(negedge clk); clear_i = 0;
    endtask

    task automatic test_reset_mid_pad();
        int t = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); s_valid_i = 1; s_data_i = WW'($urandom); s_last_i = (i == 10);
        end
        @(negedge clk); s_valid_i = 0; s_last_i = 0;
        while (fill_level_o !== 20 && t < 40) begin @(negedge clk); t++; end
        tests++; if (t >= 40) begin fails++; $display("FAIL rpad_timeout: fill=%0d want 20", fill_level_o); end
        #2 rst = 0;
        #1;
        tests++; if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0) begin fails++; $display("FAIL rpad_en: got %b/%b want 0/0", mem_en_o, mem_we_o); end
        tests++; if (mem_addr_o !== 0 || mem_data_o !== 0) begin fails++; $display("FAIL rpad_addr_data: got %0d/%0h want 0/0", mem_addr_o, mem_data_o); end
        tests++; if (fill_level_o !== 0 || frame_valid_o !== 1'b0) begin fails++; $display("FAIL rpad_fill_fv: got %0d/%b want 0/0", fill_level_o, frame_valid_o); end
        tests++; if (frame_cnt_o !== 0) begin fails++; $display("FAIL rpad_cnt: got %0d want 0", frame_cnt_o); end
        @(negedge clk); rst = 1;
        @(negedge clk);
        tests++; if (s_ready_o !== 1'b1 || mem_en_o !== 1'b0) begin fails++; $display("FAIL rpad_release: ready=%b en=%b want 1/0", s_ready_o, mem_en_o); end
    endtask

    initial begin
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_full_frame();
        test_handoff_busy();
        test_short_frame();
        test_toggle_and_clear();
        test_reset_mid_pad();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
